// File: rtl/rrv2rvh_ruby_ld_resp_align.sv
// ----------------------------------------------------------------------------
// rrv2rvh_ruby_ld_resp_align
//
// Ruby-side load response aligner. Each Ruby load issued to L1D leaves its
// {offset, opcode, tag} in an in-order metadata FIFO. When the 512-bit line
// for that load returns, the addressed bytes are extracted, sign- or
// zero-extended to 64 bits and presented to Ruby on a registered valid/ready
// port.
//
// Optional feature macro: RUBY_LDALIGN_MISALIGN_CHK_EN
//   defined   : ruby_resp_misalign_o flags offset not a multiple of the access
//               size, registered alongside the data.
//   undefined : ruby_resp_misalign_o is tied to 0.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   req_vld_i/req_rdy_o   load issue handshake (rdy = FIFO not full)
//   req_offset_i          byte offset within the 64B line
//   req_opcode_i          LDU opcode (LB..LD, LBU..LWU, 7 reserved)
//   req_tag_i             Ruby load tag
//   l1d_resp_vld_i/rdy_o  L1D line data handshake (in request order)
//   l1d_resp_data_i       full line, byte 0 at bits [7:0]
//   ruby_resp_vld_o/rdy_i aligned result handshake
//   ruby_resp_data_o      extended load result
//   ruby_resp_tag_o       tag of result
//   ruby_resp_misalign_o  misaligned access flag
//   underflow_err_o       sticky: line data arrived with no outstanding load
// ----------------------------------------------------------------------------
module rrv2rvh_ruby_ld_resp_align #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_vld_i,
    output logic               req_rdy_o,
    input  logic [5:0]         req_offset_i,
    input  logic [2:0]         req_opcode_i,
    input  logic [TAG_W-1:0]   req_tag_i,
    input  logic               l1d_resp_vld_i,
    output logic               l1d_resp_rdy_o,
    input  logic [511:0]       l1d_resp_data_i,
    output logic               ruby_resp_vld_o,
    input  logic               ruby_resp_rdy_i,
    output logic [63:0]        ruby_resp_data_o,
    output logic [TAG_W-1:0]   ruby_resp_tag_o,
    output logic               ruby_resp_misalign_o,
    output logic               underflow_err_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DATA_W = 64;

    typedef struct packed {
        logic [5:0]       offset;
        logic [2:0]       opcode;
        logic [TAG_W-1:0] tag;
    } meta_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Metadata FIFO storage and pointers
    meta_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic l1d_take;
    meta_t head;

    // Output register state
    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              underflow_q;

    logic [8:0]        shamt;
    logic [DATA_W-1:0] line_shift;
    logic [DATA_W-1:0] aligned;

    assign fifo_full  = (cnt_q == CNT_W'(DEPTH));
    assign fifo_empty = (cnt_q == '0);

    // Full blocks new requests even if a pop frees a slot this cycle
    assign req_rdy_o       = !fifo_full;
    assign ruby_resp_vld_o = (state_q == ST_FULL);
    assign l1d_resp_rdy_o  = !ruby_resp_vld_o | ruby_resp_rdy_i;

    assign push     = req_vld_i & req_rdy_o;
    assign l1d_take = l1d_resp_vld_i & l1d_resp_rdy_o;
    assign pop      = l1d_take & !fifo_empty;
    assign head     = mem[rd_ptr_q];

    // FIFO payload write; storage needs no reset, validity lives in cnt_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{offset: req_offset_i, opcode: req_opcode_i, tag: req_tag_i};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Byte extraction: shifting past byte 63 brings in zeros
    assign shamt      = {head.offset, 3'b000};
    assign line_shift = DATA_W'(l1d_resp_data_i >> shamt);

    // Size selection and sign/zero extension by opcode
    always_comb begin
        aligned = '0;
        case (head.opcode)
            3'd0: aligned = {{56{line_shift[7]}},  line_shift[7:0]};
            3'd1: aligned = {{48{line_shift[15]}}, line_shift[15:0]};
            3'd2: aligned = {{32{line_shift[31]}}, line_shift[31:0]};
            3'd3: aligned = line_shift;
            3'd4: aligned = {56'd0, line_shift[7:0]};
            3'd5: aligned = {48'd0, line_shift[15:0]};
            3'd6: aligned = {32'd0, line_shift[31:0]};
            default: aligned = '0;
        endcase
    end

`ifdef RUBY_LDALIGN_MISALIGN_CHK_EN
    logic mis_q, mis_d;
    logic misalign;

    // Offset not a multiple of access size; bytes and reserved never flag
    always_comb begin
        misalign = 1'b0;
        case (head.opcode)
            3'd1, 3'd5: misalign = head.offset[0];
            3'd2, 3'd6: misalign = |head.offset[1:0];
            3'd3:       misalign = |head.offset[2:0];
            default:    misalign = 1'b0;
        endcase
    end

    assign ruby_resp_misalign_o = mis_q;
`else
    assign ruby_resp_misalign_o = 1'b0;
`endif

    // Output register next-state; a pop in FULL reloads in place
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tag_d   = tag_q;
`ifdef RUBY_LDALIGN_MISALIGN_CHK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (pop) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!pop && ruby_resp_rdy_i) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (pop) begin
            data_d = aligned;
            tag_d  = head.tag;
`ifdef RUBY_LDALIGN_MISALIGN_CHK_EN
            mis_d  = misalign;
`endif
        end
    end

    // Output register state and payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            tag_q   <= '0;
`ifdef RUBY_LDALIGN_MISALIGN_CHK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
`ifdef RUBY_LDALIGN_MISALIGN_CHK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign ruby_resp_data_o = data_q;
    assign ruby_resp_tag_o  = tag_q;

    // Sticky underflow: line data with no outstanding metadata is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_q <= 1'b0;
        end else if (l1d_take && fifo_empty) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow_err_o = underflow_q;

endmodule
